// File: rtl/control_unit.sv
// Multi-cycle sequencer for the d16 core: fetch, optional immediate fetch, decode,
// execute, optional memory access and writeback, with memory timeout and halt/resume.
module control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_ready,
  input  logic       needs_imm,
  input  logic       is_mem,
  input  logic       is_store,
  input  logic       should_branch,
  input  logic       alu_write,
  input  logic       halt_req,
  input  logic       resume,
  output logic [2:0] state,
  output logic       en_fetch,
  output logic       en_decode,
  output logic       en_alu,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       rd_write,
  output logic       halted,
  output logic       bus_error
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_FETCH_IMM = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          cur_state;
  state_t          nxt_state;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            lat_is_mem;
  logic            lat_is_store;
  logic            lat_branch;
  logic            lat_alu_write;
  logic            halt_pending;
  logic            halt_pending_nxt;
  logic            wait_state;
  logic            timed_out;

  assign state  = cur_state;
  assign halted = (cur_state == S_HALT);

  // States that hold a memory request open and are subject to the timeout.
  always_comb begin
    wait_state = (cur_state == S_FETCH) || (cur_state == S_FETCH_IMM) ||
                 (cur_state == S_MEM);
    timed_out  = wait_state && !mem_ready && (to_cnt == TO_LIMIT);
  end

  always_comb begin
    to_cnt_nxt = '0;
    if (wait_state && !mem_ready && !timed_out) begin
      to_cnt_nxt = to_cnt + TO_W'(1);
    end
  end

  // Next-state and strobe decode; strobes are forced low while reset is held.
  always_comb begin
    nxt_state = cur_state;
    en_fetch  = 1'b0;
    en_decode = 1'b0;
    en_alu    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    rd_write  = 1'b0;

    case (cur_state)
      S_FETCH: begin
        en_fetch = 1'b1;
        mem_req  = 1'b1;
        if (mem_ready) begin
          pc_inc    = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          pc_inc    = 1'b1;
          nxt_state = S_EXECUTE;
        end
      end
      S_DECODE: begin
        en_decode = 1'b1;
        nxt_state = needs_imm ? S_FETCH_IMM : S_EXECUTE;
      end
      S_EXECUTE: begin
        en_alu    = 1'b1;
        nxt_state = is_mem ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = lat_is_mem && lat_is_store;
        if (mem_ready) begin
          nxt_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        rd_write  = lat_alu_write;
        pc_load   = lat_branch;
        nxt_state = (halt_pending || halt_req) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        nxt_state = resume ? S_FETCH : S_HALT;
      end
      default: begin
        nxt_state = S_FETCH;
      end
    endcase

    if (timed_out) begin
      nxt_state = S_HALT;
    end

    if (!rst_n) begin
      en_fetch  = 1'b0;
      en_decode = 1'b0;
      en_alu    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      rd_write  = 1'b0;
    end
  end

  // A pending halt is consumed by entering HALT; otherwise it accumulates requests.
  always_comb begin
    halt_pending_nxt = halt_pending || halt_req;
    if (nxt_state == S_HALT) begin
      halt_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt        <= '0;
      bus_error     <= 1'b0;
      halt_pending  <= 1'b0;
      lat_is_mem    <= 1'b0;
      lat_is_store  <= 1'b0;
      lat_branch    <= 1'b0;
      lat_alu_write <= 1'b0;
    end else begin
      to_cnt       <= to_cnt_nxt;
      halt_pending <= halt_pending_nxt;
      if (timed_out) begin
        bus_error <= 1'b1;
      end
      if (cur_state == S_EXECUTE) begin
        lat_is_mem    <= is_mem;
        lat_is_store  <= is_store;
        lat_branch    <= should_branch;
        lat_alu_write <= alu_write;
      end
    end
  end

  // PC strobes are mutually exclusive and requests only come from memory states.
  a_pc_excl: assert property (@(posedge clk) disable iff (!rst_n) !(pc_inc && pc_load));
  a_req_src: assert property (@(posedge clk) disable iff (!rst_n) mem_req |-> wait_state);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded bench for control_unit: per-cycle expected strobe vectors are queued
// as inputs are driven and compared against the DUT one time unit after each falling edge.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic       mem_ready, needs_imm, is_mem, is_store;
  logic       should_branch, alu_write, halt_req, resume;
  logic [2:0] state;
  logic       en_fetch, en_decode, en_alu, mem_req, mem_we;
  logic       pc_inc, pc_load, rd_write, halted, bus_error;

  control_unit #(.MEM_TIMEOUT(4), .TO_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_ready     (mem_ready),
    .needs_imm     (needs_imm),
    .is_mem        (is_mem),
    .is_store      (is_store),
    .should_branch (should_branch),
    .alu_write     (alu_write),
    .halt_req      (halt_req),
    .resume        (resume),
    .state         (state),
    .en_fetch      (en_fetch),
    .en_decode     (en_decode),
    .en_alu        (en_alu),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .rd_write      (rd_write),
    .halted        (halted),
    .bus_error     (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input masks: {mem_ready, needs_imm, is_mem, is_store, should_branch, alu_write, halt_req, resume}
  localparam logic [7:0] RDY = 8'h80, IMM = 8'h40, MEM = 8'h20, ST = 8'h10;
  localparam logic [7:0] BR  = 8'h08, AW  = 8'h04, HR  = 8'h02, RES = 8'h01;
  localparam logic [7:0] NONE = 8'h00;

  // Output masks below the 3-bit state field.
  localparam logic [9:0] EF = 10'h200, ED = 10'h100, EA = 10'h080, MR = 10'h040, MW = 10'h020;
  localparam logic [9:0] PI = 10'h010, PL = 10'h008, RW = 10'h004, HA = 10'h002, BE = 10'h001;
  localparam logic [9:0] Z  = 10'h000;

  typedef struct {
    int          id;
    logic [12:0] v;
  } sb_t;

  sb_t  sb[$];
  int   step_id  = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [12:0] obs;
  assign obs = {state, en_fetch, en_decode, en_alu, mem_req, mem_we,
                pc_inc, pc_load, rd_write, halted, bus_error};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] e(input logic [2:0] st, input logic [9:0] m);
    return {st, m};
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what the DUT must show.
  task automatic step(input logic rst, input logic [7:0] in, input logic [12:0] exp);
    sb_t item;
    @(negedge clk);
    rst_n = rst;
    {mem_ready, needs_imm, is_mem, is_store, should_branch, alu_write, halt_req, resume} = in;
    item.id = step_id;
    item.v  = exp;
    sb.push_back(item);
    step_id++;
  endtask

  initial begin : monitor
    sb_t item;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        item = sb.pop_front();
        check($sformatf("step%0d", item.id), 32'(obs), 32'(item.v));
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    {mem_ready, needs_imm, is_mem, is_store, should_branch, alu_write, halt_req, resume} = NONE;

    // Reset held with mem_ready high: state FETCH but every strobe low.
    step(1'b0, RDY | AW, e(3'd0, Z));

    // Register op, zero-wait: 0,2,3,5 then FETCH again.
    step(1'b1, RDY | AW, e(3'd0, EF | MR | PI));
    step(1'b1, RDY | AW, e(3'd2, ED));
    step(1'b1, RDY | AW, e(3'd3, EA));
    step(1'b1, RDY | AW, e(3'd5, RW));

    // Immediate + store: 0,2,1,3,4,5 with two pc_inc pulses.
    step(1'b1, RDY | IMM | MEM | ST, e(3'd0, EF | MR | PI));
    step(1'b1, RDY | IMM | MEM | ST, e(3'd2, ED));
    step(1'b1, RDY | IMM | MEM | ST, e(3'd1, MR | PI));
    step(1'b1, RDY | IMM | MEM | ST, e(3'd3, EA));
    step(1'b1, RDY | IMM | MEM | ST, e(3'd4, MR | MW));
    step(1'b1, RDY | IMM | MEM | ST, e(3'd5, Z));

    // Branch latched in EXECUTE, inputs dropped before WRITEBACK.
    step(1'b1, RDY | BR,      e(3'd0, EF | MR | PI));
    step(1'b1, RDY | BR,      e(3'd2, ED));
    step(1'b1, RDY | BR | AW, e(3'd3, EA));
    step(1'b1, RDY,           e(3'd5, PL | RW));

    // Three wait states in FETCH, below the timeout.
    step(1'b1, NONE, e(3'd0, EF | MR));
    step(1'b1, NONE, e(3'd0, EF | MR));
    step(1'b1, NONE, e(3'd0, EF | MR));
    step(1'b1, RDY,  e(3'd0, EF | MR | PI));
    step(1'b1, RDY,  e(3'd2, ED));
    step(1'b1, RDY,  e(3'd3, EA));
    step(1'b1, RDY,  e(3'd5, Z));

    // halt_req pulsed in DECODE: instruction retires, then HALT until resume.
    step(1'b1, RDY | AW,      e(3'd0, EF | MR | PI));
    step(1'b1, RDY | AW | HR, e(3'd2, ED));
    step(1'b1, RDY | AW,      e(3'd3, EA));
    step(1'b1, RDY | AW,      e(3'd5, RW));
    step(1'b1, RDY,           e(3'd6, HA));
    step(1'b1, RDY,           e(3'd6, HA));
    step(1'b1, RES,           e(3'd6, HA));

    // Memory timeout (limit 4): five MEM cycles, then HALT with bus_error.
    step(1'b1, RDY | MEM, e(3'd0, EF | MR | PI));
    step(1'b1, RDY | MEM, e(3'd2, ED));
    step(1'b1, RDY | MEM, e(3'd3, EA));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, NONE, e(3'd4, MR));
    end
    step(1'b1, NONE,     e(3'd6, HA | BE));
    step(1'b1, NONE,     e(3'd6, HA | BE));
    // Resume wins over a simultaneous halt_req; bus_error stays set.
    step(1'b1, HR | RES, e(3'd6, HA | BE));
    step(1'b1, NONE,     e(3'd0, EF | MR | BE));

    // Store with writeback intent, reset asserted mid-MEM.
    step(1'b1, RDY | MEM | ST | AW, e(3'd0, EF | MR | PI | BE));
    step(1'b1, RDY | MEM | ST | AW, e(3'd2, ED | BE));
    step(1'b1, RDY | MEM | ST | AW, e(3'd3, EA | BE));
    step(1'b1, NONE,                e(3'd4, MR | MW | BE));
    step(1'b0, RDY | MEM | ST | AW, e(3'd0, Z));
    step(1'b0, RDY | MEM | ST | AW, e(3'd0, Z));

    // Clean restart after reset: no leftover halt or error.
    step(1'b1, RDY | AW, e(3'd0, EF | MR | PI));
    step(1'b1, RDY | AW, e(3'd2, ED));
    step(1'b1, RDY | AW, e(3'd3, EA));
    step(1'b1, RDY | AW, e(3'd5, RW));
    step(1'b1, RDY | AW, e(3'd0, EF | MR | PI));

    repeat (3) @(negedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
